// File: rtl/seq_pkg.sv
// Shared definitions for the seq_pattern_gen / seq_detector serial link:
// FSM state encoding, default detect pattern and a counter-width helper.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } seq_state_e;

    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_expect_model.sv
// Predicts the registered detect output of a non-overlapping Moore detector
// watching the serial stream; used only when SEQ_PATTERN_GEN_EXPECT_EN is set.
module seq_expect_model
    import seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic seq_in,
    output logic exp_detect
);

    localparam int               CNT_W   = cnt_width(PAT_W + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(PAT_W);

    logic [PAT_W-1:0] hist_r;
    logic [CNT_W-1:0] cnt_r;
    logic             exp_detect_r;
    logic [PAT_W-1:0] hist_s;
    logic [CNT_W-1:0] cnt_now_s;
    logic             match_s;

    // Window including the bit currently on the line; count saturates so a
    // match is only allowed once a full fresh pattern has been seen.
    always_comb begin
        hist_s    = (hist_r << 1'b1) | PAT_W'(seq_in);
        cnt_now_s = (cnt_r == CNT_SAT) ? CNT_SAT : cnt_r + CNT_W'(1);
        match_s   = (hist_s == PATTERN) && (cnt_now_s == CNT_SAT);
    end

    // History, match counter and registered detect pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r       <= '0;
            cnt_r        <= '0;
            exp_detect_r <= 1'b0;
        end else begin
            hist_r       <= hist_s;
            exp_detect_r <= match_s;
            cnt_r        <= match_s ? '0 : cnt_now_s;
        end
    end

    assign exp_detect = exp_detect_r;

endmodule

// File: rtl/seq_pattern_gen.sv
// MSB-first serializer with valid/ready input and optional inter-word gap.
// Define SEQ_PATTERN_GEN_EXPECT_EN to build the detector expectation model (exp_detect).
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int               WORD_W     = 8,
    parameter int               PAT_W      = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN    = DEF_PATTERN,
    parameter int               GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              seq_out,
    output logic              busy,
    output logic              word_done
`ifdef SEQ_PATTERN_GEN_EXPECT_EN
    ,
    output logic              exp_detect
`endif
);

    localparam int                BIT_CW   = cnt_width(WORD_W);
    localparam int                GAP_CW   = cnt_width(GAP_CYCLES + 1);
    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(WORD_W - 1);
    localparam logic [GAP_CW-1:0] LAST_GAP = GAP_CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit                NO_GAP   = (GAP_CYCLES == 0);
    localparam bit                ONE_BIT  = (WORD_W == 1);

    seq_state_e        state_r;
    logic [WORD_W-1:0] shift_r;
    logic [BIT_CW-1:0] bit_cnt_r;
    logic [GAP_CW-1:0] gap_cnt_r;
    logic              seq_out_r;
    logic              word_done_r;
    logic              last_bit_s;
    logic              accept_s;

    assign last_bit_s = (state_r == SHIFT) && (bit_cnt_r == LAST_BIT);
    // Ready in IDLE, and on the last bit when there is no gap so words stream without a bubble.
    assign in_ready   = (state_r == IDLE) || (last_bit_s && NO_GAP);
    assign accept_s   = in_valid && in_ready;
    assign busy       = (state_r != IDLE);
    assign seq_out    = seq_out_r;
    assign word_done  = word_done_r;

    // Serializer FSM: the MSB goes straight to seq_out on accept, the rest waits in shift_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            seq_out_r   <= 1'b0;
            word_done_r <= 1'b0;
        end else if (accept_s) begin
            state_r     <= SHIFT;
            shift_r     <= in_data << 1'b1;
            bit_cnt_r   <= '0;
            seq_out_r   <= in_data[WORD_W-1];
            word_done_r <= ONE_BIT;
        end else begin
            case (state_r)
                IDLE: begin
                    seq_out_r   <= 1'b0;
                    word_done_r <= 1'b0;
                end
                SHIFT: begin
                    if (!last_bit_s) begin
                        seq_out_r   <= shift_r[WORD_W-1];
                        shift_r     <= shift_r << 1'b1;
                        bit_cnt_r   <= bit_cnt_r + BIT_CW'(1);
                        word_done_r <= ((bit_cnt_r + BIT_CW'(1)) == LAST_BIT);
                    end else if (!NO_GAP) begin
                        state_r     <= GAP;
                        gap_cnt_r   <= '0;
                        seq_out_r   <= 1'b0;
                        word_done_r <= 1'b0;
                    end else begin
                        state_r     <= IDLE;
                        seq_out_r   <= 1'b0;
                        word_done_r <= 1'b0;
                    end
                end
                GAP: begin
                    seq_out_r   <= 1'b0;
                    word_done_r <= 1'b0;
                    if (gap_cnt_r == LAST_GAP) begin
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_CW'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    seq_out_r   <= 1'b0;
                    word_done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_PATTERN_GEN_EXPECT_EN
    seq_expect_model #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_expect (
        .clk        (clk),
        .reset      (reset),
        .seq_in     (seq_out_r),
        .exp_detect (exp_detect)
    );
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench: dut0 streams with no gap, dut1 has GAP_CYCLES=3.
// Expected per-cycle outputs are queued on accept and popped by a separate monitor.
module tb_seq_pattern_gen;

    localparam int         W      = 8;
    localparam int         PW     = 4;
    localparam logic [3:0] TB_PAT = 4'b1011;

    typedef struct packed {
        logic b;
        logic done;
        logic gap;
    } entry_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       va = 1'b0, vb = 1'b0;
    logic [7:0] da = 8'h00, db = 8'h00;
    logic [1:0] rdy_v, so_v, busy_v, done_v;
`ifdef SEQ_PATTERN_GEN_EXPECT_EN
    logic [1:0] det_v;
`endif

    entry_t     sbq [2][$];
    bit         exp_ready [2];
    bit         accepted [2];
    bit         det_pend [2];
    int         since [2];
    logic [3:0] hist_w [2];
    bit         mon_en = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(.WORD_W(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(va), .in_ready(rdy_v[0]), .in_data(da),
        .seq_out(so_v[0]), .busy(busy_v[0]), .word_done(done_v[0])
`ifdef SEQ_PATTERN_GEN_EXPECT_EN
        , .exp_detect(det_v[0])
`endif
    );

    seq_pattern_gen #(.WORD_W(W), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .in_valid(vb), .in_ready(rdy_v[1]), .in_data(db),
        .seq_out(so_v[1]), .busy(busy_v[1]), .word_done(done_v[1])
`ifdef SEQ_PATTERN_GEN_EXPECT_EN
        , .exp_detect(det_v[1])
`endif
    );

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string nm, input int d, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t actual=%b required=%b", nm, d, $time, act, exp);
        end
    endtask

    // A word occupies W bit cycles (MSB first, done on the last) plus its gap cycles.
    task automatic push_word(input int d, input logic [7:0] data);
        for (int i = W - 1; i >= 0; i--) begin
            sbq[d].push_back('{b: data[i], done: (i == 0), gap: 1'b0});
        end
        for (int g = 0; g < gap_of(d); g++) begin
            sbq[d].push_back('{b: 1'b0, done: 1'b0, gap: 1'b1});
        end
    endtask

    // Accept side of the model: sees each edge, queues what the accepted word will produce.
    initial forever begin
        @(posedge clk);
        accepted[0] = 1'b0;
        accepted[1] = 1'b0;
        if (reset) begin
            sbq[0].delete();
            sbq[1].delete();
        end else begin
            if (va && exp_ready[0]) begin
                push_word(0, da);
                accepted[0] = 1'b1;
            end
            if (vb && exp_ready[1]) begin
                push_word(1, db);
                accepted[1] = 1'b1;
            end
        end
    end

    // Monitor: pops the expectation for this cycle and compares every output.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                entry_t e;
                bit     have;
                have = (sbq[d].size() > 0);
                if (have) e = sbq[d].pop_front();
                else      e = '{b: 1'b0, done: 1'b0, gap: 1'b0};
                exp_ready[d] = (sbq[d].size() == 0) && !e.gap;
                check("seq_out", d, so_v[d], e.b);
                check("word_done", d, done_v[d], e.done);
                check("busy", d, busy_v[d], have);
                check("in_ready", d, rdy_v[d], exp_ready[d]);
`ifdef SEQ_PATTERN_GEN_EXPECT_EN
                check("exp_detect", d, det_v[d], det_pend[d]);
`endif
                hist_w[d] = {hist_w[d][2:0], e.b};
                since[d]  = (since[d] < PW) ? since[d] + 1 : PW;
                if (hist_w[d] == TB_PAT && since[d] >= PW) begin
                    det_pend[d] = 1'b1;
                    since[d]    = 0;
                end else begin
                    det_pend[d] = 1'b0;
                end
                if (reset) begin
                    det_pend[d] = 1'b0;
                    since[d]    = 0;
                    hist_w[d]   = 4'h0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d);
        bit got;
        got = 1'b0;
        va  = 1'b1;
        da  = d;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = accepted[0];
        end
        va = 1'b0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL accept_timeout dut0 word=%h actual=not_accepted required=accepted", d);
        end
    endtask

    // dut1 sees mostly-held valid with fresh random data, exercising gap backpressure.
    initial forever begin
        step();
        vb = ($urandom_range(0, 4) != 0);
        db = 8'($urandom);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) step();
        send_a(8'hB0);
        repeat (12) step();
        send_a(8'hB6);
        repeat (12) step();
        send_a(8'hB0);
        send_a(8'h0B);
        repeat (20) step();
        send_a(8'hFF);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();
        for (int c = 0; c < 3000; c++) begin
            va    = ($urandom_range(0, 3) != 0);
            da    = ($urandom_range(0, 2) == 0) ? {4'b1011, 4'($urandom)} : 8'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        va    = 1'b0;
        repeat (40) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter paired with `seq_detector`, the other end of the single-bit serial link. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first on `seq_out`, one bit per clock. An optional reference model predicts the exact cycle on which a non-overlapping Moore detector for `PATTERN` raises its detect output, for use by the scoreboard.

## Interface
- `WORD_W`, default 8: width of each word accepted for serialization; must be ≥ 1.
- `PAT_W`, default 4: width of the detect pattern; must be ≥ 1.
- `PATTERN`, default 4'b1011: target sequence, MSB sent first.
- `GAP_CYCLES`, default 0: idle cycles (`seq_out` = 0) inserted after each word.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: word offered.
- `in_ready` out 1: word accepted when both `in_valid` and `in_ready` are high at a rising edge.
- `in_data` in `WORD_W`: word to serialize.
- `seq_out` out 1: registered serial bit, the stream fed to the detector's `seq_in`.
- `busy` out 1: high in SHIFT or GAP.
- `word_done` out 1: one-cycle pulse while the last bit of a word is on `seq_out`.
- `exp_detect` out 1: predicted detector output. Present only with `SEQ_PATTERN_GEN_EXPECT_EN`.

## Operation
- Reset values: state = IDLE, `seq_out` = 0, `busy` = 0, `word_done` = 0, `exp_detect` = 0. The shift register, bit counter, gap counter and history are all cleared.
- Reset mid-operation aborts the current word with no `word_done` and clears the expectation model.
- FSM states and transitions:
  - IDLE: `in_ready` = 1 and `seq_out` = 0. On accept, load the shift register and go to SHIFT.
  - SHIFT: one bit per cycle for `WORD_W` cycles, counted by `bit_cnt` from 0 to `WORD_W`-1.
  - After the last bit: go to GAP if `GAP_CYCLES` > 0, otherwise go to IDLE.
  - GAP: `seq_out` = 0 for `GAP_CYCLES` cycles, then go to IDLE.
- Back-to-back streaming:
  - `in_ready` is also high during the last SHIFT cycle when `GAP_CYCLES` == 0.
  - An accept on that cycle reloads the shift register and stays in SHIFT, so the stream has no bubble.
- Backpressure: `in_ready` is low at all other times. `in_data` is ignored when no accept occurs.
- Bit order: `in_data[WORD_W-1]` goes first.
- Counter widths:
  - Bit counter: $clog2(`WORD_W`) bits, minimum 1.
  - Gap counter: $clog2(`GAP_CYCLES`+1) bits, minimum 1.
  - Neither counter wraps: each is reloaded on entry to its state.

## Timing
- The word is accepted at edge k. `in_data[WORD_W-1]` is on `seq_out` during cycle k+1, and bit 0 during cycle k+`WORD_W`.
- `word_done` is high during cycle k+`WORD_W`.
- With the default `GAP_CYCLES` = 0 and `in_valid` held high, the next word's MSB appears in cycle k+`WORD_W`+1.
- With `GAP_CYCLES` = G, `in_ready` rises in cycle k+`WORD_W`+G+1.
- `exp_detect` timing:
  - It is high for exactly one cycle, the cycle after the final `PATTERN` bit is on `seq_out`. This matches a registered Moore detect.
  - It is never high on two consecutive cycles.

## Configuration
- `SEQ_PATTERN_GEN_EXPECT_EN` defined: the expectation model is built and the `exp_detect` port exists.
  - The model keeps a `PAT_W`-bit history of emitted `seq_out` values, including idle zeros.
  - It also keeps a count of cycles since the last match, saturating at `PAT_W`.
  - Match condition: history == `PATTERN` and count ≥ `PAT_W`. A match pulses `exp_detect` next cycle and zeroes the count. This is the non-overlapping rule.
- Macro undefined: no model logic and no `exp_detect` port. The serializer behaviour is identical.

## Structure
- Shared package `seq_pkg` holds:
  - the FSM state enum (IDLE, SHIFT, GAP);
  - the default `PATTERN` and `PAT_W` constants, also used by `seq_detector` benches.
- One sub-module, `seq_expect_model` (history plus match counter), instantiated only under the macro.

## Test plan
All scenarios use `WORD_W`=8, `GAP_CYCLES`=0 unless stated otherwise.
- Single word: 8'hB0 accepted at edge 0 → `seq_out` = 1,0,1,1,0,0,0,0 in cycles 1–8; `word_done` in cycle 8; `exp_detect` in cycle 5 only.
- Non-overlap: 8'b1011_0110 → bits 1,0,1,1,0,1,1,0; exactly one `exp_detect`, in cycle 5. The overlapping 1011 ending in cycle 7 gives no pulse.
- Back-to-back: 8'hB0 then 8'h0B with `in_valid` held → second word's MSB in cycle 9, no idle bit between words; `exp_detect` in cycles 5 and 17.
- Gap/backpressure: `GAP_CYCLES`=3, `in_valid` held → `in_ready` low in cycles 1–11; `seq_out` = 0 in cycles 9–11; next word's MSB in cycle 13.
- Reset mid-word: assert `reset` in cycle 4 of 8'hFF → `seq_out` = 0, `busy` = 0, no `word_done`, `in_ready` = 1 in the following cycle.
- Macro off: rerun the single-word case → identical `seq_out` and `word_done`; `exp_detect` port absent.
